// File: rtl/qracc_pkg.sv
`timescale 1ns/1ps
// qracc_pkg: shared types for the QRAcc control path.
//   qracc_config_t       - layer configuration as presented by the CSR block
//   qracc_sched_state_t  - window scheduler FSM state; encodings are visible
//                          to software through the CSR internal-state field
package qracc_pkg;

    localparam int QRACC_DIM_W    = 16;
    localparam int QRACC_STRIDE_W = 4;

    typedef struct packed {
        logic [QRACC_DIM_W-1:0]    output_fmap_dimx;
        logic [QRACC_DIM_W-1:0]    output_fmap_dimy;
        logic [QRACC_STRIDE_W-1:0] stride_x;
        logic [QRACC_STRIDE_W-1:0] stride_y;
    } qracc_config_t;

    typedef enum logic [3:0] {
        SCHED_IDLE  = 4'd0,
        SCHED_ISSUE = 4'd1,
        SCHED_WAIT  = 4'd2,
        SCHED_DONE  = 4'd3
    } qracc_sched_state_t;

endpackage

// File: rtl/qracc_xy_counter.sv
`timescale 1ns/1ps
// qracc_xy_counter: raster-order x/y counter.
//   clk, rst  - clock and synchronous active-high reset
//   clr_i     - zero both counters (takes priority over adv_i)
//   adv_i     - step to the next pixel: x+1, or wrap x to 0 and y+1
//   dimx_i/dimy_i - current extent used for wrap and last detection
//   x_o, y_o  - registered coordinates
//   last_o    - (x,y) equals (dimx-1, dimy-1)
module qracc_xy_counter #(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] dimx_i,
    input  logic [DIM_W-1:0] dimy_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             last_o
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             x_at_end;

    assign x_at_end = (x_q == dimx_i - DIM_W'(1));
    assign last_o   = x_at_end && (y_q == dimy_i - DIM_W'(1));
    assign x_o      = x_q;
    assign y_o      = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/qracc_window_scheduler.sv
`timescale 1ns/1ps
// qracc_window_scheduler: walks the output feature map of one layer in raster
// order and issues one window request per output pixel, waiting for each
// window to retire before issuing the next.
//   clk, rst              - clock, synchronous active-high reset
//   start_i, clear_i      - CSR start / abort pulses (clear has priority)
//   cfg_i                 - layer config, sampled only when a start is taken
//   win_valid_o/ready_i   - request handshake to the compute datapath
//   win_ox_o/oy_o         - output pixel coordinate
//   win_ix_o/iy_o         - input window top-left (coordinate * stride)
//   win_last_o            - current coordinate is the final pixel
//   win_done_i            - datapath retired the accepted window
//   busy_o, state_o       - CSR readback
//   layer_done_o          - one-cycle pulse on layer completion
module qracc_window_scheduler
    import qracc_pkg::*;
#(
    parameter int DIM_W    = 16,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                clear_i,
    input  qracc_config_t       cfg_i,
    output logic                win_valid_o,
    input  logic                win_ready_i,
    output logic [DIM_W-1:0]    win_ox_o,
    output logic [DIM_W-1:0]    win_oy_o,
    output logic [DIM_W-1:0]    win_ix_o,
    output logic [DIM_W-1:0]    win_iy_o,
    output logic                win_last_o,
    input  logic                win_done_i,
    output logic                busy_o,
    output logic [3:0]          state_o,
    output logic                layer_done_o
);

    qracc_sched_state_t   state_q, state_d;
    logic [DIM_W-1:0]     dimx_q, dimx_d;
    logic [DIM_W-1:0]     dimy_q, dimy_d;
    logic [STRIDE_W-1:0]  sx_q, sx_d;
    logic [STRIDE_W-1:0]  sy_q, sy_d;

    logic [DIM_W-1:0]     cfg_dimx, cfg_dimy;
    logic [STRIDE_W-1:0]  cfg_sx, cfg_sy;
    logic                 cnt_clr, cnt_adv, cnt_last;
    logic [DIM_W-1:0]     ox, oy;

    assign cfg_dimx = DIM_W'(cfg_i.output_fmap_dimx);
    assign cfg_dimy = DIM_W'(cfg_i.output_fmap_dimy);
    assign cfg_sx   = STRIDE_W'(cfg_i.stride_x);
    assign cfg_sy   = STRIDE_W'(cfg_i.stride_y);

    always_comb begin
        state_d = state_q;
        dimx_d  = dimx_q;
        dimy_d  = dimy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        if (clear_i) begin
            state_d = SCHED_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    if (start_i) begin
                        dimx_d  = cfg_dimx;
                        dimy_d  = cfg_dimy;
                        // A zero stride would collapse every window onto the
                        // origin; treat it as unit stride instead.
                        sx_d    = (cfg_sx == '0) ? STRIDE_W'(1) : cfg_sx;
                        sy_d    = (cfg_sy == '0) ? STRIDE_W'(1) : cfg_sy;
                        cnt_clr = 1'b1;
                        state_d = (cfg_dimx == '0 || cfg_dimy == '0) ? SCHED_DONE
                                                                       : SCHED_ISSUE;
                    end
                end
                SCHED_ISSUE: begin
                    if (win_ready_i) state_d = SCHED_WAIT;
                end
                SCHED_WAIT: begin
                    if (win_done_i) begin
                        // The counter steps past the final pixel as well; it is
                        // re-zeroed by the next start, so nothing downstream sees it.
                        cnt_adv = 1'b1;
                        state_d = cnt_last ? SCHED_DONE : SCHED_ISSUE;
                    end
                end
                SCHED_DONE: state_d = SCHED_IDLE;
                default:    state_d = SCHED_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCHED_IDLE;
            dimx_q  <= '0;
            dimy_q  <= '0;
            sx_q    <= STRIDE_W'(1);
            sy_q    <= STRIDE_W'(1);
        end else begin
            state_q <= state_d;
            dimx_q  <= dimx_d;
            dimy_q  <= dimy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    qracc_xy_counter #(.DIM_W(DIM_W)) u_xy (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .dimx_i (dimx_q),
        .dimy_i (dimy_q),
        .x_o    (ox),
        .y_o    (oy),
        .last_o (cnt_last)
    );

    assign win_valid_o  = (state_q == SCHED_ISSUE);
    assign layer_done_o = (state_q == SCHED_DONE);
    assign busy_o       = (state_q != SCHED_IDLE);
    assign state_o      = state_q;
    assign win_ox_o     = ox;
    assign win_oy_o     = oy;
    assign win_last_o   = cnt_last;
    // Products are evaluated at DIM_W bits, so overflow wraps silently.
    assign win_ix_o     = ox * DIM_W'(sx_q);
    assign win_iy_o     = oy * DIM_W'(sy_q);

endmodule

// File: tb/tb_qracc_window_scheduler.sv
`timescale 1ns/1ps
module tb_qracc_window_scheduler;
    import qracc_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, clear_i;
    qracc_config_t cfg_i;
    logic          win_valid_o, win_ready_i;
    logic [15:0]   win_ox_o, win_oy_o, win_ix_o, win_iy_o;
    logic          win_last_o, win_done_i;
    logic          busy_o, layer_done_o;
    logic [3:0]    state_o;

    int  total = 0;
    int  bad   = 0;
    bit  tie_ready = 1'b0;

    always #5 clk = ~clk;

    qracc_window_scheduler #(.DIM_W(16), .STRIDE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .clear_i      (clear_i),
        .cfg_i        (cfg_i),
        .win_valid_o  (win_valid_o),
        .win_ready_i  (win_ready_i),
        .win_ox_o     (win_ox_o),
        .win_oy_o     (win_oy_o),
        .win_ix_o     (win_ix_o),
        .win_iy_o     (win_iy_o),
        .win_last_o   (win_last_o),
        .win_done_i   (win_done_i),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .layer_done_o (layer_done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int dx, input int dy, input int sx, input int sy);
        cfg_i.output_fmap_dimx = 16'(dx);
        cfg_i.output_fmap_dimy = 16'(dy);
        cfg_i.stride_x         = 4'(sx);
        cfg_i.stride_y         = 4'(sy);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Serve one window: wait (bounded) for the request, check it, optionally
    // hold ready low for 'hold' cycles, accept, then retire it one cycle later.
    task automatic do_window(input int eox, input int eoy, input int eix, input int eiy,
                             input logic elast, input int hold, input bit poke_start);
        int n = 0;
        while (!win_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("valid_seen", 32'(win_valid_o), 32'd1);
        check("ox", 32'(win_ox_o), 32'(eox));
        check("oy", 32'(win_oy_o), 32'(eoy));
        check("ix", 32'(win_ix_o), 32'(eix));
        check("iy", 32'(win_iy_o), 32'(eiy));
        check("last", 32'(win_last_o), 32'(elast));
        check("no_layer_done", 32'(layer_done_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            // A done pulse while waiting for ready must not move the counters.
            if (i == 0) win_done_i = 1'b1;
            tick();
            win_done_i = 1'b0;
            check("hold_valid", 32'(win_valid_o), 32'd1);
            check("hold_ox", 32'(win_ox_o), 32'(eox));
            check("hold_oy", 32'(win_oy_o), 32'(eoy));
            check("hold_ix", 32'(win_ix_o), 32'(eix));
        end
        win_ready_i = 1'b1;
        tick();
        win_ready_i = tie_ready;
        $display("req ox=%0d oy=%0d ix=%0d iy=%0d last=%0d", eox, eoy, eix, eiy, elast);
        check("accept_to_wait", 32'(state_o), 32'd2);
        check("valid_drop", 32'(win_valid_o), 32'd0);
        if (poke_start) start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("wait_hold", 32'(state_o), 32'd2);
        win_done_i = 1'b1;
        tick();
        win_done_i = 1'b0;
    endtask

    task automatic expect_layer_end();
        check("layer_done_pulse", 32'(layer_done_o), 32'd1);
        check("done_state", 32'(state_o), 32'd3);
        check("done_busy", 32'(busy_o), 32'd1);
        tick();
        check("layer_done_single", 32'(layer_done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);
        check("idle_valid", 32'(win_valid_o), 32'd0);
    endtask

    initial begin
        int t1x[6] = '{0, 1, 2, 0, 1, 2};
        int t1y[6] = '{0, 0, 0, 1, 1, 1};
        int t2x[4] = '{0, 1, 0, 1};
        int t2y[4] = '{0, 0, 1, 1};

        rst = 1'b1; start_i = 1'b0; clear_i = 1'b0;
        win_ready_i = 1'b0; win_done_i = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(win_valid_o), 32'd0);
        check("rst_last", 32'(win_last_o), 32'd0);
        check("rst_done", 32'(layer_done_o), 32'd0);
        check("rst_coords", 32'({win_ox_o, win_oy_o}), 32'd0);
        check("rst_incoords", 32'({win_ix_o, win_iy_o}), 32'd0);

        // 3x2 layer, stride 1, ready tied high
        tie_ready = 1'b1;
        win_ready_i = 1'b1;
        set_cfg(3, 2, 1, 1);
        pulse_start();
        check("start_latency_valid", 32'(win_valid_o), 32'd1);
        check("start_busy", 32'(busy_o), 32'd1);
        for (int k = 0; k < 6; k++)
            do_window(t1x[k], t1y[k], t1x[k], t1y[k], (k == 5), 0, 1'b0);
        expect_layer_end();
        tie_ready = 1'b0;
        win_ready_i = 1'b0;

        // 2x2 layer, stride_x=2 stride_y=3
        set_cfg(2, 2, 2, 3);
        pulse_start();
        for (int k = 0; k < 4; k++)
            do_window(t2x[k], t2y[k], 2 * t2x[k], 3 * t2y[k], (k == 3), 0, 1'b0);
        expect_layer_end();

        // 2x1 layer stride 3, ready held low 5 cycles on the first request;
        // config rewritten mid-layer and a start pulsed during WAIT
        set_cfg(2, 1, 3, 3);
        pulse_start();
        set_cfg(5, 4, 1, 1);
        do_window(0, 0, 0, 0, 1'b0, 5, 1'b1);
        do_window(1, 0, 3, 0, 1'b1, 0, 1'b0);
        expect_layer_end();

        // Clear while in WAIT at pixel (1,0)
        set_cfg(3, 2, 1, 1);
        pulse_start();
        do_window(0, 0, 0, 0, 1'b0, 0, 1'b0);
        check("pre_clear_ox", 32'(win_ox_o), 32'd1);
        win_ready_i = 1'b1;
        tick();
        win_ready_i = 1'b0;
        check("pre_clear_wait", 32'(state_o), 32'd2);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_busy", 32'(busy_o), 32'd0);
        check("clear_state", 32'(state_o), 32'd0);
        check("clear_valid", 32'(win_valid_o), 32'd0);
        check("clear_no_done", 32'(layer_done_o), 32'd0);
        tick();
        check("clear_no_done_late", 32'(layer_done_o), 32'd0);
        pulse_start();
        check("restart_valid", 32'(win_valid_o), 32'd1);
        check("restart_ox", 32'(win_ox_o), 32'd0);
        check("restart_oy", 32'(win_oy_o), 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_issue_state", 32'(state_o), 32'd0);

        // Zero dimension: done one cycle after start, no request
        set_cfg(0, 3, 1, 1);
        pulse_start();
        check("zero_dim_valid", 32'(win_valid_o), 32'd0);
        expect_layer_end();

        // Stride 0 behaves as stride 1
        set_cfg(2, 1, 0, 0);
        pulse_start();
        do_window(0, 0, 0, 0, 1'b0, 0, 1'b0);
        do_window(1, 0, 1, 0, 1'b1, 0, 1'b0);
        expect_layer_end();

        // Simultaneous start and clear: stays idle
        set_cfg(2, 2, 1, 1);
        start_i = 1'b1;
        clear_i = 1'b1;
        tick();
        start_i = 1'b0;
        clear_i = 1'b0;
        check("start_clear_state", 32'(state_o), 32'd0);
        check("start_clear_valid", 32'(win_valid_o), 32'd0);
        tick();
        check("start_clear_no_done", 32'(layer_done_o), 32'd0);
        check("start_clear_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
